// File: rtl/sram_confreg.sv
// sram_confreg: configuration / peripheral register target on the CPU data
// SRAM interface. Holds scratch registers, a free-running timer with a sticky
// compare interrupt, LED and number-display registers, a synchronized switch
// input and a read-only simulation flag. Reads return one cycle after the
// request; write accesses also return the pre-write register value.
module sram_confreg #(
  parameter bit SIMULATION = 1'b1,
  parameter int SW_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sram_en,
  input  logic [3:0]      sram_wen,
  input  logic [31:0]     sram_addr,
  input  logic [31:0]     sram_wdata,
  output logic [31:0]     sram_rdata,
  input  logic [SW_W-1:0] switch,
  output logic [15:0]     led,
  output logic [31:0]     num_data,
  output logic            timer_int
);

  // Word addresses (byte offset >> 2) of the non-scratch registers.
  localparam logic [13:0] A_TIMER   = 14'h0400;
  localparam logic [13:0] A_COMPARE = 14'h0401;
  localparam logic [13:0] A_CTRL    = 14'h0402;
  localparam logic [13:0] A_LED     = 14'h3C00;
  localparam logic [13:0] A_NUM     = 14'h3C04;
  localparam logic [13:0] A_SWITCH  = 14'h3C08;
  localparam logic [13:0] A_SIMU    = 14'h3FFC;

  localparam logic [31:0] SIMU_VALUE = SIMULATION ? 32'hFFFF_FFFF : 32'h0000_0000;

  // Replace the enabled byte lanes of old with data.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] mask,
                                        input logic [31:0] data);
    return (old & ~mask) | (data & mask);
  endfunction

  logic [13:0]     word_addr;
  logic            unused_addr;
  logic            wr_en;
  logic [31:0]     byte_mask;
  logic [7:0]      cr_hit;
  logic            hit_timer;
  logic            hit_compare;
  logic            hit_ctrl;
  logic            hit_led;
  logic            hit_num;

  logic [31:0]     cr_reg [8];
  logic [31:0]     timer_reg;
  logic [31:0]     compare_reg;
  logic [1:0]      ctrl_reg;
  logic [15:0]     led_reg;
  logic [31:0]     num_reg;
  logic [SW_W-1:0] sw_meta_reg;
  logic [SW_W-1:0] sw_sync_reg;
  logic [31:0]     rdata_reg;
  logic            timer_int_reg;

  logic [31:0]     read_value;
  logic [31:0]     timer_next;
  logic            timer_en;
  logic            int_en;
  logic            match;

  // Only addr[15:2] selects a register; the window decode happens outside.
  assign word_addr   = sram_addr[15:2];
  assign unused_addr = ^{sram_addr[31:16], sram_addr[1:0]};
  assign wr_en       = sram_en & (|sram_wen);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_mask[gi*8 +: 8] = {8{sram_wen[gi]}};
    end
    for (gi = 0; gi < 8; gi++) begin : g_cr_hit
      assign cr_hit[gi] = wr_en && (word_addr == 14'(gi));
    end
  endgenerate

  assign hit_timer   = wr_en && (word_addr == A_TIMER);
  assign hit_compare = wr_en && (word_addr == A_COMPARE);
  assign hit_ctrl    = wr_en && (word_addr == A_CTRL);
  assign hit_led     = wr_en && (word_addr == A_LED);
  assign hit_num     = wr_en && (word_addr == A_NUM);

  assign timer_en = ctrl_reg[0];
  assign int_en   = ctrl_reg[1];
  assign match    = timer_en & int_en & (timer_reg == compare_reg);

  // Register read mux; unmapped offsets read zero.
  always_comb begin
    read_value = '0;
    if (word_addr[13:3] == '0) begin
      read_value = cr_reg[word_addr[2:0]];
    end else begin
      case (word_addr)
        A_TIMER:   read_value = timer_reg;
        A_COMPARE: read_value = compare_reg;
        A_CTRL:    read_value = {30'b0, ctrl_reg};
        A_LED:     read_value = {16'b0, led_reg};
        A_NUM:     read_value = num_reg;
        A_SWITCH:  read_value = 32'(sw_sync_reg);
        A_SIMU:    read_value = SIMU_VALUE;
        default:   read_value = '0;
      endcase
    end
  end

  // Timer: a bus write beats the increment; unwritten bytes keep the
  // pre-increment value.
  always_comb begin
    timer_next = timer_reg;
    if (hit_timer) begin
      timer_next = merge(timer_reg, byte_mask, sram_wdata);
    end else if (timer_en) begin
      timer_next = timer_reg + 32'd1;
    end
  end

  // Scratch registers CR0..CR7.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset) begin
        cr_reg[i] <= '0;
      end else if (cr_hit[i]) begin
        cr_reg[i] <= merge(cr_reg[i], byte_mask, sram_wdata);
      end
    end
  end

  // Timer, compare, control, LED and number-display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg   <= '0;
      compare_reg <= '0;
      ctrl_reg    <= '0;
      led_reg     <= '0;
      num_reg     <= '0;
    end else begin
      timer_reg <= timer_next;
      if (hit_compare) compare_reg <= merge(compare_reg, byte_mask, sram_wdata);
      if (hit_ctrl && sram_wen[0]) ctrl_reg <= sram_wdata[1:0];
      if (hit_led) led_reg <= merge({16'b0, led_reg}, byte_mask, sram_wdata) >> 0;
      if (hit_num) num_reg <= merge(num_reg, byte_mask, sram_wdata);
    end
  end

  // Sticky compare interrupt; any COMPARE write clears it and wins over a
  // simultaneous match.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_int_reg <= 1'b0;
    end else if (hit_compare) begin
      timer_int_reg <= 1'b0;
    end else if (match) begin
      timer_int_reg <= 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= switch;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // Registered read data; captures the pre-write value on writes and holds
  // when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (sram_en) begin
      rdata_reg <= read_value;
    end
  end

  assign sram_rdata = rdata_reg;
  assign led        = led_reg;
  assign num_data   = num_reg;
  assign timer_int  = timer_int_reg;

endmodule

// File: tb/tb_sram_confreg.sv
// Self-checking bench for sram_confreg: a cycle model predicts read data and
// outputs, expected read data is queued at request time and compared after
// the edge; directed checks pin the key values of the register behaviour.
module tb_sram_confreg;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_int;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  logic [31:0] exp_q [$];

  // Reference model state.
  logic [31:0] m_cr [8];
  logic [31:0] m_timer, m_compare, m_num, m_rdata;
  logic [1:0]  m_ctrl;
  logic [15:0] m_led;
  logic [7:0]  m_sync1, m_sync2;
  logic        m_int;

  always #5 clk = ~clk;

  sram_confreg #(.SIMULATION(1'b1), .SW_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .switch     (switch),
    .led        (led),
    .num_data   (num_data),
    .timer_int  (timer_int)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wen[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a_in);
    logic [15:0] a;
    a = a_in & 16'hFFFC;
    if (a < 16'h0020) return m_cr[a[4:2]];
    case (a)
      16'h1000: return m_timer;
      16'h1004: return m_compare;
      16'h1008: return {30'b0, m_ctrl};
      16'hF000: return {16'b0, m_led};
      16'hF010: return m_num;
      16'hF020: return {24'b0, m_sync2};
      16'hFFF0: return 32'hFFFF_FFFF;
      default:  return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step(output logic [31:0] exp);
    logic [15:0] a;
    logic        wr, mt;
    logic [31:0] t_next, tmp;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_cr[i] = '0;
      m_timer = '0; m_compare = '0; m_ctrl = '0; m_led = '0; m_num = '0;
      m_sync1 = '0; m_sync2 = '0; m_int = 1'b0; m_rdata = '0;
      exp = '0;
    end else begin
      a      = sram_addr[15:0] & 16'hFFFC;
      wr     = sram_en && (sram_wen != 4'b0);
      exp    = sram_en ? m_read(sram_addr[15:0]) : m_rdata;
      mt     = (m_ctrl == 2'b11) && (m_timer == m_compare);
      t_next = m_ctrl[0] ? m_timer + 32'd1 : m_timer;
      if (wr) begin
        if (a < 16'h0020) m_cr[a[4:2]] = bmerge(m_cr[a[4:2]], sram_wdata, sram_wen);
        case (a)
          16'h1000: t_next = bmerge(m_timer, sram_wdata, sram_wen);
          16'h1004: m_compare = bmerge(m_compare, sram_wdata, sram_wen);
          16'h1008: if (sram_wen[0]) m_ctrl = sram_wdata[1:0];
          16'hF000: begin
            tmp   = bmerge({16'b0, m_led}, sram_wdata, sram_wen);
            m_led = tmp[15:0];
          end
          16'hF010: m_num = bmerge(m_num, sram_wdata, sram_wen);
          default: ;
        endcase
      end
      if (wr && a == 16'h1004) m_int = 1'b0;
      else if (mt) m_int = 1'b1;
      m_timer = t_next;
      m_sync2 = m_sync1;
      m_sync1 = switch;
      m_rdata = exp;
    end
  endtask

  // One bus cycle: drive, predict, clock, compare.
  task automatic do_cycle(input logic rst, input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp;
    reset = rst; sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    model_step(exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d rst=%b en=%b wen=%h addr=%08h wdata=%08h rdata=%08h int=%b",
             n_txn, rst, en, wen, addr, wdata, sram_rdata, timer_int);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      check("rdata", sram_rdata, exp_q.pop_front());
    end
    check("led", {16'b0, led}, {16'b0, m_led});
    check("num_data", num_data, m_num);
    check("timer_int", {31'b0, timer_int}, {31'b0, m_int});
  endtask

  task automatic rd(input logic [31:0] addr);
    do_cycle(1'b0, 1'b1, 4'b0000, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] d);
    do_cycle(1'b0, 1'b1, wen, addr, d);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  logic [31:0] addr_tbl [16] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                                 32'h1000, 32'h1004, 32'h1008, 32'hF000, 32'hF010,
                                 32'hF020, 32'hFFF0, 32'h2003};

  initial begin
    reset = 1'b1; sram_en = 1'b0; sram_wen = '0; sram_addr = '0; sram_wdata = '0;
    switch = 8'h00;
    @(posedge clk); #1;

    // Reset and reset-state reads.
    do_cycle(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
    do_cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'hDEAD_BEEF);
    rd(32'h0000);  check("rst_cr0", sram_rdata, 32'h0);
    rd(32'h1000);  check("rst_timer", sram_rdata, 32'h0);
    rd(32'hF000);  check("rst_led_reg", sram_rdata, 32'h0);
    rd(32'hFFF0);  check("simu_flag", sram_rdata, 32'hFFFF_FFFF);
    check("rst_led", {16'b0, led}, 32'h0);
    check("rst_int", {31'b0, timer_int}, 32'h0);

    // Byte-enable merge and read-before-write on CR3.
    wr(32'h000C, 4'hF, 32'h1234_5678); check("cr3_prewrite0", sram_rdata, 32'h0);
    wr(32'h000C, 4'h5, 32'hAABB_CCDD); check("cr3_prewrite", sram_rdata, 32'h1234_5678);
    rd(32'h000C);                      check("cr3_merge", sram_rdata, 32'h12BB_56DD);
    idle();                            check("rdata_hold", sram_rdata, 32'h12BB_56DD);
    for (int i = 0; i < 8; i++) wr(32'(i * 4), 4'hF, $urandom());
    for (int i = 0; i < 8; i++) rd(32'(i * 4));

    // LED, NUM and unmapped offsets.
    wr(32'hF000, 4'hF, 32'hFFFF_ABCD);
    rd(32'hF000);  check("led_read", sram_rdata, 32'h0000_ABCD);
    check("led_out", {16'b0, led}, 32'h0000_ABCD);
    wr(32'hF010, 4'hF, 32'hCAFE_F00D);
    rd(32'hF010);  check("num_read", sram_rdata, 32'hCAFE_F00D);
    wr(32'h2000, 4'hF, 32'h5555_5555);
    rd(32'h2000);  check("unmapped", sram_rdata, 32'h0);

    // Switch synchronizer latency; writes to SWITCH are ignored.
    switch = 8'hA5;
    rd(32'hF020);  check("sw_lat0", sram_rdata, 32'h0);
    rd(32'hF020);  check("sw_lat1", sram_rdata, 32'h0);
    rd(32'hF020);  check("sw_lat2", sram_rdata, 32'h0000_00A5);
    wr(32'hF020, 4'hF, 32'h0);
    rd(32'hF020);  check("sw_ro", sram_rdata, 32'h0000_00A5);

    // Timer compare interrupt.
    wr(32'h1004, 4'hF, 32'd5);
    wr(32'h1008, 4'hF, 32'd3);
    wr(32'h1000, 4'hF, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      idle();
      if (i == 5) check("int_before", {31'b0, timer_int}, 32'h0);
      if (i == 6) check("int_rise", {31'b0, timer_int}, 32'h1);
    end
    rd(32'h1000);  check("timer_after_rise", sram_rdata, 32'd8);
    wr(32'h1004, 4'hF, 32'd100);
    check("int_clear", {31'b0, timer_int}, 32'h0);

    // Wrap and write priority over increment.
    wr(32'h1008, 4'hF, 32'd1);
    wr(32'h1000, 4'hF, 32'hFFFF_FFFE);
    idle();
    idle();
    rd(32'h1000);  check("timer_wrap", sram_rdata, 32'h0);
    wr(32'h1000, 4'hF, 32'h0000_1234);
    rd(32'h1000);  check("timer_wr_prio", sram_rdata, 32'h0000_1234);
    wr(32'h1000, 4'h1, 32'h0000_00AA);
    rd(32'h1000);

    // Match coinciding with a COMPARE write: clear wins.
    wr(32'h1008, 4'hF, 32'd3);
    wr(32'h1004, 4'hF, 32'd50);
    wr(32'h1000, 4'hF, 32'd48);
    idle();
    idle();
    wr(32'h1004, 4'hF, 32'd200);
    check("int_clear_wins", {31'b0, timer_int}, 32'h0);
    idle();
    check("int_stays0", {31'b0, timer_int}, 32'h0);

    // Reset with the interrupt set and a LED write in flight.
    wr(32'h1008, 4'hF, 32'd0);
    wr(32'h1000, 4'hF, 32'd7);
    wr(32'h1004, 4'hF, 32'd7);
    wr(32'h1008, 4'hF, 32'd3);
    idle();
    check("int_set", {31'b0, timer_int}, 32'h1);
    do_cycle(1'b1, 1'b1, 4'hF, 32'hF000, 32'h0000_FFFF);
    check("rst_int_clr", {31'b0, timer_int}, 32'h0);
    check("rst_led_clr", {16'b0, led}, 32'h0);
    check("rst_rdata", sram_rdata, 32'h0);
    rd(32'h000C);  check("rst_cr3", sram_rdata, 32'h0);

    // Random mixed traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom());
      switch = 8'($urandom());
      do_cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), w,
               addr_tbl[$urandom_range(0, 15)], $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_confreg.md
Name: sram_confreg

Overview:
- Memory-mapped configuration and peripheral register responder on the CPU data SRAM interface. This is the target side of the en/wen/addr/wdata/rdata protocol that mycpu_top drives.
- Provides scratch registers, a free-running timer with compare interrupt, LED and number-display outputs, a synchronized switch input and a simulation flag.
- Sits beside the data RAM; an external address decoder gates `sram_en` when `addr[31:16]` selects the confreg window.
- `timer_int` feeds `ext_int_in[5]`.

Parameters:
- SIMULATION, 1, 1 makes SIMU_FLAG read 0xFFFFFFFF; 0 makes it read 0x00000000.
- SW_W, 8, width of the switch input.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- sram_en  input  1  access request, already qualified by the external window decode.
- sram_wen  input  4  byte write enables; 0000 means read.
- sram_addr  input  32  byte address; only `addr[15:2]` is decoded.
- sram_wdata  input  32  write data.
- sram_rdata  output  32  read data, registered.
- switch  input  SW_W  asynchronous board switches.
- led  output  16  LED register.
- num_data  output  32  number-display register.
- timer_int  output  1  sticky timer compare interrupt, level.

Behaviour:
- Register map (offsets in `addr[15:0]`; `addr[1:0]` ignored):
  - 0x0000–0x001C: CR0–CR7, RW, 32 bits.
  - 0x1000: TIMER, RW.
  - 0x1004: COMPARE, RW.
  - 0x1008: CTRL, RW. bit0 = timer_en, bit1 = int_en, bits 31:2 read 0.
  - 0xF000: LED, RW, bits 15:0; upper bits read 0.
  - 0xF010: NUM, RW.
  - 0xF020: SWITCH, RO, zero-extended.
  - 0xFFF0: SIMU_FLAG, RO.
  - Any other offset reads 0; writes to it are ignored. Writes to RO registers are ignored.
- Writes:
  - Occur when `sram_en=1` and `sram_wen!=0`.
  - Only bytes whose enable bit is set are updated.
  - The register updates at the clock edge, visible to a read issued the following cycle.
- Reads:
  - Occur when `sram_en=1`; latency is exactly 1 cycle.
  - `sram_rdata` is registered from the addressed register's value before the edge.
  - On a write access (`en=1`, `wen!=0`), `sram_rdata` also loads the pre-write value of the addressed register (read-before-write).
  - When `sram_en=0`, `sram_rdata` holds its previous value.
- Back-to-back accesses are accepted every cycle; there is no stall and no backpressure.
- Switch path: 2-flop synchronizer. SWITCH reads the second flop, so a switch change is visible to reads issued 2 cycles later.
- Timer:
  - If timer_en=1, TIMER increments by 1 every cycle, wrapping 0xFFFFFFFF to 0x00000000.
  - A TIMER write takes priority over the increment in the same cycle; the written bytes are loaded and unwritten bytes keep their pre-increment values.
- Interrupt:
  - Match condition: timer_en & int_en & (TIMER == COMPARE), evaluated on current register values.
  - On match, `timer_int` sets at the next edge and stays set.
  - It is cleared only by any write to COMPARE or by reset.
  - A COMPARE write in the same cycle as a match: the clear wins and `timer_int` stays 0.
  - Clearing int_en does not clear an already-set `timer_int`.
- Outputs `led` and `num_data` are direct register outputs.
- Reset (synchronous, active-high) clears:
  - CR0–CR7, TIMER, COMPARE, CTRL, LED, NUM → 0.
  - Both synchronizer flops → 0.
  - `sram_rdata` = 0 and `timer_int` = 0.
- Reset asserted mid-access: the access is discarded; the next cycle shows reset values.
- Reset has priority over every write and over the timer increment.

Test Plan:
- Reset, then read 0x0000, 0x1000, 0xF000, 0xFFF0 with SIMULATION=1 → rdata 0, 0, 0, 0xFFFFFFFF; led=0, timer_int=0.
- Write CR3 (0x000C) 0x12345678 with wen=1111, then write 0xAABBCCDD with wen=0101, then read → rdata 0x12BB56DD one cycle after the read request; the write cycle itself returns 0x12345678.
- Write COMPARE=5 and CTRL=3, then TIMER=0 → TIMER reaches 5 and timer_int rises one edge later. Timer keeps counting, so reading TIMER 3 cycles after the rise returns 8. Writing COMPARE=100 clears timer_int at the next edge.
- TIMER=0xFFFFFFFE with timer_en=1 → two cycles later a TIMER read shows 0x00000000 (wrap); a TIMER write coinciding with the increment loads the written value exactly.
- switch changes 0x00→0xA5 → a read issued in the cycle of the change or the next returns 0x00; a read issued 2 cycles after returns 0x000000A5. A write to 0xF020 is ignored.
- Match and COMPARE write in the same cycle → timer_int stays 0. Assert reset while timer_int=1 and a LED write is in flight → timer_int=0 and led=0 next cycle.
